// File: rtl/vga_pkg.sv
// Shared types and constants for the screen sequencing path.
// Holds the sequencer state encoding and the per-channel fade helper.
package vga_pkg;

    typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} seq_state_t;

    localparam logic [4:0] FADE_MAX  = 5'd16;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    // Scales one 4-bit colour channel by level/16; level 16 is exact pass-through.
    function automatic logic [3:0] fade_channel(input logic [3:0] c, input logic [4:0] level);
        logic [7:0] prod;
        prod = {4'b0000, c} * {3'b000, level};
        return prod[7:4];
    endfunction

endpackage

// File: rtl/rgb_fader.sv
// Brightness scaler for the 12-bit {r,g,b} bus with blanking gate.
// One registered stage so RGB stays aligned with the delayed sync signals.
module rgb_fader
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  level,
    input  logic        blank,
    input  logic [11:0] rgb_in,
    output logic [11:0] rgb_out
);

    logic [11:0] faded;

    always_comb begin
        faded = '0;
        if (!blank) begin
            faded = {fade_channel(rgb_in[11:8], level),
                     fade_channel(rgb_in[7:4],  level),
                     fade_channel(rgb_in[3:0],  level)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= faded;
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// Active-screen selector driven by PS/2 keys, with frame-synchronised
// fade-out / swap / fade-in transitions applied to the RGB stream.
module screen_sequencer
    import vga_pkg::*;
#(
    parameter int          N_SCREENS       = 4,
    parameter int          FRAMES_PER_STEP = 2,
    parameter logic [7:0]  KEY_NEXT        = 8'h74,
    parameter logic [7:0]  KEY_PREV        = 8'h6B,
    parameter logic [7:0]  KEY_HOME        = 8'h76,
    localparam int         SCR_W           = (N_SCREENS > 1) ? $clog2(N_SCREENS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      keycode,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [11:0]      rgb_in,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [11:0]      rgb_out,
    output logic [SCR_W-1:0] screen_idx,
    output logic             busy
);

    localparam int               CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [SCR_W-1:0] IDX_LAST = SCR_W'(N_SCREENS - 1);

    seq_state_t       state;
    logic [SCR_W-1:0] target;
    logic [SCR_W-1:0] target_q;
    logic [4:0]       level;
    logic [CNT_W-1:0] frame_cnt;
    logic [15:0]      keycode_q;
    logic             vblnk_q;
    logic             key_valid;
    logic             key_event;
    logic             frame_tick;

    always_comb begin
        target    = screen_idx;
        key_valid = 1'b1;
        case (keycode[7:0])
            KEY_NEXT: target = (screen_idx == IDX_LAST) ? '0 : screen_idx + 1'b1;
            KEY_PREV: target = (screen_idx == '0) ? IDX_LAST : screen_idx - 1'b1;
            KEY_HOME: target = '0;
            default:  key_valid = 1'b0;
        endcase
    end

    assign key_event  = (keycode != keycode_q) && (keycode[15:8] != PS2_BREAK) && key_valid;
    assign frame_tick = vblnk_in & ~vblnk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            screen_idx <= '0;
            target_q   <= '0;
            level      <= FADE_MAX;
            frame_cnt  <= '0;
            keycode_q  <= '0;
            vblnk_q    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            keycode_q <= keycode;
            vblnk_q   <= vblnk_in;
            case (state)
                IDLE: begin
                    // A same-cycle frame tick is deliberately not counted here.
                    if (key_event && (target != screen_idx)) begin
                        target_q  <= target;
                        frame_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= FADE_OUT;
                    end
                end
                FADE_OUT: begin
                    if (frame_tick) begin
                        if (frame_cnt == CNT_LAST) begin
                            frame_cnt <= '0;
                            level     <= level - 1'b1;
                            if (level == 5'd1) state <= SWAP;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                SWAP: begin
                    screen_idx <= target_q;
                    state      <= FADE_IN;
                end
                FADE_IN: begin
                    if (frame_tick) begin
                        if (frame_cnt == CNT_LAST) begin
                            frame_cnt <= '0;
                            level     <= level + 1'b1;
                            if (level == FADE_MAX - 5'd1) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            hblnk_out <= 1'b0;
            vblnk_out <= 1'b0;
        end else begin
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
            hblnk_out <= hblnk_in;
            vblnk_out <= vblnk_in;
        end
    end

    rgb_fader u_rgb_fader (
        .clk     (clk),
        .rst     (rst),
        .level   (level),
        .blank   (hblnk_in | vblnk_in),
        .rgb_in  (rgb_in),
        .rgb_out (rgb_out)
    );

endmodule

// File: tb/tb_screen_sequencer.sv
// Randomised self-checking bench for screen_sequencer (N_SCREENS=3, FRAMES_PER_STEP=1).
// The reference model tracks transitions as a count of frame ticks since the key press.
module tb_screen_sequencer;

    localparam int N   = 3;
    localparam int FPS = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keycode;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [1:0]  screen_idx;
    logic        busy;

    always #5 clk = ~clk;

    screen_sequencer #(
        .N_SCREENS       (N),
        .FRAMES_PER_STEP (FPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keycode    (keycode),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .screen_idx (screen_idx),
        .busy       (busy)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: a transition is "active" for 32*FPS counted ticks,
    // with one swap cycle (ticks ignored) after the 16*FPS-th tick.
    int          m_idx, m_tgt, m_n;
    bit          m_active, m_swap_now, m_swapped;
    logic [15:0] m_key;
    logic        m_vb;

    logic [11:0] exp_rgb;
    logic [3:0]  exp_sync;
    logic        exp_busy;
    logic [1:0]  exp_idx;

    function automatic int m_level();
        if (!m_active)       return 16;
        if (m_n <= 16 * FPS) return 16 - m_n / FPS;
        return (m_n - 16 * FPS) / FPS;
    endfunction

    function automatic logic [11:0] scale(input logic [11:0] c, input int lv);
        int r, g, b;
        r = int'(c[11:8]) * lv / 16;
        g = int'(c[7:4])  * lv / 16;
        b = int'(c[3:0])  * lv / 16;
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic model_reset();
        m_idx = 0; m_tgt = 0; m_n = 0;
        m_active = 0; m_swap_now = 0; m_swapped = 0;
        m_key = '0; m_vb = 1'b0;
    endtask

    // Computes expectations from the current inputs, advances the model, clocks once.
    task automatic clk_cycle();
        bit ev, tk;
        int tgt;
        exp_rgb  = (hblnk_in | vblnk_in) ? 12'h000 : scale(rgb_in, m_level());
        exp_sync = {hsync_in, vsync_in, hblnk_in, vblnk_in};
        ev = (keycode != m_key) && (keycode[15:8] != 8'hF0) &&
             (keycode[7:0] == 8'h74 || keycode[7:0] == 8'h6B || keycode[7:0] == 8'h76);
        tk = vblnk_in && !m_vb;
        if (!m_active) begin
            if (ev) begin
                case (keycode[7:0])
                    8'h74:   tgt = (m_idx + 1) % N;
                    8'h6B:   tgt = (m_idx + N - 1) % N;
                    default: tgt = 0;
                endcase
                if (tgt != m_idx) begin
                    m_active = 1; m_n = 0; m_tgt = tgt; m_swapped = 0;
                end
            end
        end else if (m_swap_now) begin
            m_idx = m_tgt; m_swap_now = 0; m_swapped = 1;
        end else if (tk) begin
            m_n++;
            if (m_n == 16 * FPS && !m_swapped) m_swap_now = 1;
            if (m_n == 32 * FPS) m_active = 0;
        end
        m_key = keycode;
        m_vb  = vblnk_in;
        exp_busy = m_active;
        exp_idx  = 2'(m_idx);
        @(posedge clk);
        #1;
    endtask

    // Runs whole frames (vblank high 2 cycles, low 2) with random video, checking each cycle.
    task automatic run_frames(input int nf);
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < 4; k++) begin
                vblnk_in = (k < 2);
                hblnk_in = ($urandom % 8 == 0);
                hsync_in = 1'($urandom);
                vsync_in = 1'($urandom);
                rgb_in   = 12'($urandom);
                clk_cycle();
                total++;
                if (rgb_out !== exp_rgb) $display("FAIL frames_rgb got=%h exp=%h", rgb_out, exp_rgb); else passed++;
                total++;
                if (busy !== exp_busy) $display("FAIL frames_busy got=%b exp=%b", busy, exp_busy); else passed++;
                total++;
                if (screen_idx !== exp_idx) $display("FAIL frames_idx got=%0d exp=%0d", screen_idx, exp_idx); else passed++;
                total++;
                if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== exp_sync)
                    $display("FAIL frames_sync got=%b exp=%b", {hsync_out, vsync_out, hblnk_out, vblnk_out}, exp_sync);
                else passed++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        keycode = 16'h0000;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = 12'hFA5;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (rgb_out !== 12'h000) $display("FAIL reset_rgb got=%h exp=000", rgb_out); else passed++;
        total++;
        if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== 4'b0000)
            $display("FAIL reset_sync got=%b exp=0000", {hsync_out, vsync_out, hblnk_out, vblnk_out});
        else passed++;
        total++;
        if (busy !== 1'b0 || screen_idx !== 2'd0) $display("FAIL reset_state got busy=%b idx=%0d exp busy=0 idx=0", busy, screen_idx); else passed++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_passthrough();
        hsync_in = 1'b0; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = 12'hFA5;
        clk_cycle();
        total++;
        if (rgb_out !== 12'hFA5) $display("FAIL passthrough_rgb got=%h exp=FA5", rgb_out); else passed++;
        total++;
        if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== exp_sync)
            $display("FAIL passthrough_sync got=%b exp=%b", {hsync_out, vsync_out, hblnk_out, vblnk_out}, exp_sync);
        else passed++;
        total++;
        if (busy !== 1'b0 || screen_idx !== 2'd0) $display("FAIL passthrough_state got busy=%b idx=%0d exp busy=0 idx=0", busy, screen_idx); else passed++;
    endtask

    task automatic test_next_transition();
        keycode = 16'h0074;
        rgb_in = 12'hFA5;
        vblnk_in = 1'b0; hblnk_in = 1'b0;
        clk_cycle();
        total++;
        if (busy !== 1'b1) $display("FAIL next_busy_start got=%b exp=1", busy); else passed++;
        for (int f = 0; f < 32; f++) begin
            for (int k = 0; k < 4; k++) begin
                vblnk_in = (k < 2);
                hblnk_in = 1'b0;
                rgb_in   = (f == 7 && k == 2) ? 12'hF84 : 12'($urandom);
                if (f == 4 && k == 2) keycode = 16'h006B;
                clk_cycle();
                total++;
                if (rgb_out !== exp_rgb) $display("FAIL next_rgb f=%0d got=%h exp=%h", f, rgb_out, exp_rgb); else passed++;
                total++;
                if (busy !== exp_busy || screen_idx !== exp_idx)
                    $display("FAIL next_state f=%0d got busy=%b idx=%0d exp busy=%b idx=%0d", f, busy, screen_idx, exp_busy, exp_idx);
                else passed++;
                if (f == 7 && k == 2) begin
                    total++;
                    if (rgb_out !== 12'h742) $display("FAIL next_level8 got=%h exp=742", rgb_out); else passed++;
                end
                if (f == 15 && k == 3) begin
                    total++;
                    if (rgb_out !== 12'h000 || screen_idx !== 2'd1)
                        $display("FAIL next_black_swap got rgb=%h idx=%0d exp rgb=000 idx=1", rgb_out, screen_idx);
                    else passed++;
                end
            end
        end
        vblnk_in = 1'b0;
        rgb_in = 12'hFA5;
        clk_cycle();
        total++;
        if (rgb_out !== 12'hFA5 || busy !== 1'b0 || screen_idx !== 2'd1)
            $display("FAIL next_done got rgb=%h busy=%b idx=%0d exp rgb=FA5 busy=0 idx=1", rgb_out, busy, screen_idx);
        else passed++;
    endtask

    task automatic test_wrap();
        keycode = 16'h0076;
        vblnk_in = 1'b0;
        clk_cycle();
        run_frames(33);
        total++;
        if (screen_idx !== 2'd0 || busy !== 1'b0) $display("FAIL wrap_home got idx=%0d busy=%b exp idx=0 busy=0", screen_idx, busy); else passed++;
        keycode = 16'hE06B;
        vblnk_in = 1'b0;
        clk_cycle();
        run_frames(33);
        total++;
        if (screen_idx !== 2'd2) $display("FAIL wrap_prev got=%0d exp=2", screen_idx); else passed++;
        keycode = 16'hE074;
        vblnk_in = 1'b0;
        clk_cycle();
        run_frames(33);
        total++;
        if (screen_idx !== 2'd0) $display("FAIL wrap_next got=%0d exp=2'd0", screen_idx); else passed++;
        keycode = 16'h0076;
        vblnk_in = 1'b0;
        clk_cycle();
        total++;
        if (busy !== 1'b0) $display("FAIL home_at_zero got busy=%b exp=0", busy); else passed++;
        run_frames(2);
    endtask

    task automatic test_break_repeat();
        keycode = 16'hF074;
        vblnk_in = 1'b0;
        clk_cycle();
        total++;
        if (busy !== 1'b0) $display("FAIL break_next got busy=%b exp=0", busy); else passed++;
        run_frames(2);
        keycode = 16'hF06B;
        clk_cycle();
        run_frames(2);
        total++;
        if (busy !== 1'b0 || screen_idx !== 2'd0) $display("FAIL break_prev got busy=%b idx=%0d exp busy=0 idx=0", busy, screen_idx); else passed++;
        keycode = 16'hE074;
        vblnk_in = 1'b0;
        clk_cycle();
        run_frames(33);
        run_frames(3);
        total++;
        if (busy !== 1'b0 || screen_idx !== 2'd1) $display("FAIL repeat_key got busy=%b idx=%0d exp busy=0 idx=1", busy, screen_idx); else passed++;
    endtask

    task automatic test_reset_mid();
        keycode = 16'h1174;
        vblnk_in = 1'b0;
        clk_cycle();
        run_frames(16);
        run_frames(5);
        total++;
        if (m_level() != 5 || busy !== 1'b1) $display("FAIL reset_mid_setup got busy=%b exp busy=1", busy); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (rgb_out !== 12'h000 || {hsync_out, vsync_out, hblnk_out, vblnk_out} !== 4'b0000)
            $display("FAIL reset_mid_async got rgb=%h sync=%b exp rgb=000 sync=0000", rgb_out, {hsync_out, vsync_out, hblnk_out, vblnk_out});
        else passed++;
        total++;
        if (busy !== 1'b0 || screen_idx !== 2'd0) $display("FAIL reset_mid_state got busy=%b idx=%0d exp busy=0 idx=0", busy, screen_idx); else passed++;
        keycode = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        hblnk_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = 12'hFA5;
        clk_cycle();
        total++;
        if (rgb_out !== 12'hFA5 || busy !== 1'b0 || screen_idx !== 2'd0)
            $display("FAIL reset_mid_after got rgb=%h busy=%b idx=%0d exp rgb=FA5 busy=0 idx=0", rgb_out, busy, screen_idx);
        else passed++;
        hblnk_in = 1'b1;
        clk_cycle();
        total++;
        if (rgb_out !== 12'h000) $display("FAIL hblank_gate got=%h exp=000", rgb_out); else passed++;
    endtask

    task automatic test_random();
        logic [7:0] pre, code;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 30 == 0) begin
                pre = ($urandom % 3 == 0) ? 8'hF0 : 8'($urandom);
                case ($urandom % 4)
                    0:       code = 8'h74;
                    1:       code = 8'h6B;
                    2:       code = 8'h76;
                    default: code = 8'($urandom);
                endcase
                keycode = {pre, code};
            end
            vblnk_in = ($urandom % 5 == 0);
            hblnk_in = ($urandom % 8 == 0);
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            rgb_in   = 12'($urandom);
            clk_cycle();
            total++;
            if (rgb_out !== exp_rgb) $display("FAIL random_rgb i=%0d got=%h exp=%h", i, rgb_out, exp_rgb); else passed++;
            total++;
            if (busy !== exp_busy) $display("FAIL random_busy i=%0d got=%b exp=%b", i, busy, exp_busy); else passed++;
            total++;
            if (screen_idx !== exp_idx) $display("FAIL random_idx i=%0d got=%0d exp=%0d", i, screen_idx, exp_idx); else passed++;
            total++;
            if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== exp_sync)
                $display("FAIL random_sync i=%0d got=%b exp=%b", i, {hsync_out, vsync_out, hblnk_out, vblnk_out}, exp_sync);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_next_transition();
        test_wrap();
        test_break_repeat();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
